// File: rtl/udt_tx_session_ctrl.sv
// -----------------------------------------------------------------------------
// udt_tx_session_ctrl
// Transmit-path socket state owner for a UDT session. Walks
// CLOSED -> CONNECTING -> CONNECTED -> DRAINING -> CLOSED on user commands,
// handshake completion, peer close and handshake timeout. Produces the AXIS
// transmit enable; a close never cuts a packet short, the in-flight packet is
// drained through its tlast before the socket reports CLOSED.
//
// Optional build macro: UDT_TX_PKT_CNT_EN enables the completed-packet counter
// on pkt_cnt_o. Without it pkt_cnt_o is tied to zero.
//
// Ports:
//   core_clk, core_rst      clock, asynchronous active-high reset
//   cmd_connect_i           user connect pulse
//   cmd_close_i             user close pulse
//   hs_done_i               handshake complete from the protocol engine
//   peer_close_i            peer shutdown received
//   tx_axis_tvalid_i/tready_i/tlast_i   observed transmit AXIS handshake
//   tx_ready_o              transmit enable (ANDed with link tready downstream)
//   udt_state_o             registered socket state code
//   state_valid_o           1-cycle pulse on each new udt_state_o value
//   in_pkt_o                packet started, tlast not yet accepted
//   timeout_o               1-cycle pulse when the handshake times out
//   pkt_cnt_o               completed-packet count (optional)
// -----------------------------------------------------------------------------
module udt_tx_session_ctrl #(
    parameter logic [31:0] CONNECT        = 32'h0000_0001,
    parameter logic [31:0] CLOSE          = 32'h0000_0002,
    parameter logic [31:0] CONNECTING     = 32'h0000_0004,
    parameter logic [31:0] CLOSING        = 32'h0000_0008,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        cmd_connect_i,
    input  logic        cmd_close_i,
    input  logic        hs_done_i,
    input  logic        peer_close_i,
    input  logic        tx_axis_tvalid_i,
    input  logic        tx_axis_tready_i,
    input  logic        tx_axis_tlast_i,
    output logic        tx_ready_o,
    output logic [31:0] udt_state_o,
    output logic        state_valid_o,
    output logic        in_pkt_o,
    output logic        timeout_o,
    output logic [15:0] pkt_cnt_o
);

    typedef enum logic [1:0] {
        S_CLOSED,
        S_CONNECTING,
        S_CONNECTED,
        S_DRAINING
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_pkt_q, in_pkt_d;
    logic             state_valid_q, state_valid_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      udt_state_q, udt_state_d;

    logic beat_acc;
    logic close_req;

    function automatic logic [31:0] state_code(input state_e s);
        case (s)
            S_CONNECTING: state_code = CONNECTING;
            S_CONNECTED:  state_code = CONNECT;
            S_DRAINING:   state_code = CLOSING;
            default:      state_code = CLOSE;
        endcase
    endfunction

    assign beat_acc  = tx_axis_tvalid_i & tx_axis_tready_i;
    assign close_req = cmd_close_i | peer_close_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        in_pkt_d  = in_pkt_q;

        // Packet tracking runs in every state.
        if (beat_acc) begin
            in_pkt_d = ~tx_axis_tlast_i;
        end

        case (state_q)
            S_CLOSED: begin
                // A simultaneous close cancels the connect.
                if (cmd_connect_i && !close_req) begin
                    state_d = S_CONNECTING;
                    cnt_d   = '0;
                end
            end
            S_CONNECTING: begin
                cnt_d = cnt_q + 1'b1;
                if (close_req) begin
                    state_d = S_CLOSED;
                end else if (hs_done_i) begin
                    state_d = S_CONNECTED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_CLOSED;
                    timeout_d = 1'b1;
                end
            end
            S_CONNECTED: begin
                if (close_req) begin
                    state_d = S_DRAINING;
                end
            end
            S_DRAINING: begin
                // Leave once no packet is open, or right after its tlast beat.
                if (!in_pkt_q || (beat_acc && tx_axis_tlast_i)) begin
                    state_d = S_CLOSED;
                end
            end
            default: state_d = S_CLOSED;
        endcase

        udt_state_d   = state_code(state_d);
        state_valid_d = (state_d != state_q);
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q       <= S_CLOSED;
            cnt_q         <= '0;
            in_pkt_q      <= 1'b0;
            state_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            udt_state_q   <= CLOSE;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            in_pkt_q      <= in_pkt_d;
            state_valid_q <= state_valid_d;
            timeout_q     <= timeout_d;
            udt_state_q   <= udt_state_d;
        end
    end

    // Pure decode of flops: no input reaches tx_ready_o combinationally.
    assign tx_ready_o    = (state_q == S_CONNECTED) | ((state_q == S_DRAINING) & in_pkt_q);
    assign udt_state_o   = udt_state_q;
    assign state_valid_o = state_valid_q;
    assign in_pkt_o      = in_pkt_q;
    assign timeout_o     = timeout_q;

`ifdef UDT_TX_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (beat_acc && tx_axis_tlast_i) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`else
    assign pkt_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_udt_tx_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_udt_tx_session_ctrl
// Directed scenarios with literal expectations, followed by randomized
// traffic. A cycle-level reference model tracks socket state, open-packet
// status, handshake age and packet count; a compare process checks every DUT
// output against it each cycle.
// -----------------------------------------------------------------------------
module tb_udt_tx_session_ctrl;

    localparam int TO = 10;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        cmd_connect_i = 1'b0;
    logic        cmd_close_i = 1'b0;
    logic        hs_done_i = 1'b0;
    logic        peer_close_i = 1'b0;
    logic        tx_axis_tvalid_i = 1'b0;
    logic        tx_axis_tready_i = 1'b0;
    logic        tx_axis_tlast_i = 1'b0;
    logic        tx_ready_o;
    logic [31:0] udt_state_o;
    logic        state_valid_o;
    logic        in_pkt_o;
    logic        timeout_o;
    logic [15:0] pkt_cnt_o;

    udt_tx_session_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .core_clk         (core_clk),
        .core_rst         (core_rst),
        .cmd_connect_i    (cmd_connect_i),
        .cmd_close_i      (cmd_close_i),
        .hs_done_i        (hs_done_i),
        .peer_close_i     (peer_close_i),
        .tx_axis_tvalid_i (tx_axis_tvalid_i),
        .tx_axis_tready_i (tx_axis_tready_i),
        .tx_axis_tlast_i  (tx_axis_tlast_i),
        .tx_ready_o       (tx_ready_o),
        .udt_state_o      (udt_state_o),
        .state_valid_o    (state_valid_o),
        .in_pkt_o         (in_pkt_o),
        .timeout_o        (timeout_o),
        .pkt_cnt_o        (pkt_cnt_o)
    );

    always #5 core_clk = ~core_clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Socket state is held directly as its output code; handshake age is the
    // distance between the current cycle index and the first CONNECTING cycle.
    logic [31:0] m_state   = 32'h2;
    bit          m_valid   = 1'b0;
    bit          m_in_pkt  = 1'b0;
    bit          m_timeout = 1'b0;
    int unsigned m_pkt     = 0;
    longint      m_cyc     = 0;
    longint      m_entry   = 0;
    bit          m_acc, m_creq;
    logic [31:0] m_nxt;

    always @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            m_state = 32'h2; m_valid = 0; m_in_pkt = 0; m_timeout = 0;
            m_pkt = 0; m_cyc = 0; m_entry = 0;
        end else begin
            m_acc  = tx_axis_tvalid_i && tx_axis_tready_i;
            m_creq = cmd_close_i || peer_close_i;
            m_nxt  = m_state;
            m_timeout = 0;
            case (m_state)
                32'h2: if (cmd_connect_i && !m_creq) begin
                    m_nxt = 32'h4; m_entry = m_cyc + 1;
                end
                32'h4: begin
                    if (m_creq) m_nxt = 32'h2;
                    else if (hs_done_i) m_nxt = 32'h1;
                    else if (m_cyc - m_entry == TO - 1) begin
                        m_nxt = 32'h2; m_timeout = 1;
                    end
                end
                32'h1: if (m_creq) m_nxt = 32'h8;
                32'h8: if (!m_in_pkt || (m_acc && tx_axis_tlast_i)) m_nxt = 32'h2;
                default: m_nxt = 32'h2;
            endcase
            m_valid = (m_nxt != m_state);
            m_state = m_nxt;
            if (m_acc) m_in_pkt = !tx_axis_tlast_i;
`ifdef UDT_TX_PKT_CNT_EN
            if (m_acc && tx_axis_tlast_i) m_pkt = (m_pkt + 1) % 65536;
`endif
            m_cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge core_clk) begin
        #2;
        if (!done) begin
            chk("m_state",   udt_state_o, m_state);
            chk("m_valid",   {31'd0, state_valid_o}, {31'd0, m_valid});
            chk("m_in_pkt",  {31'd0, in_pkt_o}, {31'd0, m_in_pkt});
            chk("m_timeout", {31'd0, timeout_o}, {31'd0, m_timeout});
            chk("m_tx_ready", {31'd0, tx_ready_o},
                {31'd0, (m_state == 32'h1) || (m_state == 32'h8 && m_in_pkt)});
            chk("m_pkt_cnt", {16'd0, pkt_cnt_o}, m_pkt);
        end
    end

    // ---------------- stimulus ----------------
    // Hold one set of inputs over one rising edge; returns at the next falling
    // edge where the registered outputs reflect it. tready is gated by tx_ready_o.
    task automatic drive(input bit conn, input bit cls, input bit hs, input bit peer,
                         input bit v, input bit want, input bit last);
        cmd_connect_i    = conn;
        cmd_close_i      = cls;
        hs_done_i        = hs;
        peer_close_i     = peer;
        tx_axis_tvalid_i = v;
        tx_axis_tready_i = tx_ready_o & want;
        tx_axis_tlast_i  = last;
        @(negedge core_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_state"}, udt_state_o, 32'h2);
        chk({nm, "_txr"},   {31'd0, tx_ready_o}, 32'd0);
        chk({nm, "_vld"},   {31'd0, state_valid_o}, 32'd0);
        chk({nm, "_inpkt"}, {31'd0, in_pkt_o}, 32'd0);
        chk({nm, "_to"},    {31'd0, timeout_o}, 32'd0);
        chk({nm, "_cnt"},   {16'd0, pkt_cnt_o}, 32'd0);
    endtask

    task automatic connect_up;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge core_clk);
        chk_reset_vals("reset");
        core_rst = 1'b0;
        @(negedge core_clk);

        // 1: connect then handshake 5 cycles later
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("t1_connecting", udt_state_o, 32'h4);
        chk("t1_vld1", {31'd0, state_valid_o}, 32'd1);
        idle(4);
        chk("t1_vld_low", {31'd0, state_valid_o}, 32'd0);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t1_connected", udt_state_o, 32'h1);
        chk("t1_vld2", {31'd0, state_valid_o}, 32'd1);
        chk("t1_txr", {31'd0, tx_ready_o}, 32'd1);

        // 3: close mid-packet, drained to tlast
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("t3_inpkt", {31'd0, in_pkt_o}, 32'd1);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("t3_draining", udt_state_o, 32'h8);
        chk("t3_txr_drain", {31'd0, tx_ready_o}, 32'd1);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("t3_still_drain", udt_state_o, 32'h8);
        drive(0, 0, 0, 0, 1, 1, 1);
        chk("t3_closed", udt_state_o, 32'h2);
        chk("t3_txr_off", {31'd0, tx_ready_o}, 32'd0);

        // 4: peer close while idle
        connect_up();
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("t4_draining", udt_state_o, 32'h8);
        chk("t4_txr", {31'd0, tx_ready_o}, 32'd0);
        idle(1);
        chk("t4_closed", udt_state_o, 32'h2);

        // 2: handshake timeout, then handshake on the last cycle
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(TO - 1);
        chk("t2_not_yet", udt_state_o, 32'h4);
        idle(1);
        chk("t2_closed", udt_state_o, 32'h2);
        chk("t2_timeout", {31'd0, timeout_o}, 32'd1);
        idle(1);
        chk("t2_timeout_1cyc", {31'd0, timeout_o}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(TO - 1);
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("t2_hs_last", udt_state_o, 32'h1);
        chk("t2_no_timeout", {31'd0, timeout_o}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(1);

        // 5: simultaneous events
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t5_stay_closed", udt_state_o, 32'h2);
        chk("t5_no_vld", {31'd0, state_valid_o}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("t5_abort", udt_state_o, 32'h2);
        chk("t5_abort_vld", {31'd0, state_valid_o}, 32'd1);

        // 6: reset mid-packet
        connect_up();
        drive(0, 0, 0, 0, 1, 1, 0);
        core_rst = 1'b1;
        #1;
        chk_reset_vals("t6_rst");
        @(negedge core_clk);
        core_rst = 1'b0;
        @(negedge core_clk);

`ifdef UDT_TX_PKT_CNT_EN
        connect_up();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 1, 1);
        chk("t6_cnt3", {16'd0, pkt_cnt_o}, 32'd3);
        for (int i = 0; i < 65533; i++) drive(0, 0, 0, 0, 1, 1, 1);
        chk("t6_wrap", {16'd0, pkt_cnt_o}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0);
        idle(2);
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                core_rst = 1'b1;
                idle(1);
                core_rst = 1'b0;
            end else begin
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0);
            end
        end

        idle(2);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
